// File: rtl/conv_feeder_pkg.sv
// ============================================================================
// Module   : conv_feeder_pkg
// Brief    : Shared widths, MAC latency and sequencer state encoding for the
//            convolver input feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_feeder_pkg;

    localparam int WID_LINE   = 16;
    localparam int WID_FILTER = 16;
    localparam int ADDR_FIFO  = 10;
    localparam int K          = 3;
    localparam int MAC_LAT    = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLR       = 3'd1,
        LOAD_FILT = 3'd2,
        STREAM    = 3'd3,
        DRAIN     = 3'd4
    } state_e;

    // Travels alongside each MAC slot so the frame's final window is tagged.
    typedef struct packed {
        logic mac;
        logic last;
    } mac_tag_t;

endpackage

`default_nettype wire

// File: rtl/conv_feeder_if.sv
// ============================================================================
// Module   : conv_feeder_if
// Brief    : Upstream filter and pixel valid/ready streams into the feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_feeder_if #(
    parameter int WID_LINE   = conv_feeder_pkg::WID_LINE,
    parameter int WID_FILTER = conv_feeder_pkg::WID_FILTER
) ();
    import conv_feeder_pkg::*;

    logic                  filt_valid;
    logic                  filt_ready;
    logic [WID_FILTER-1:0] filt_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [WID_LINE-1:0]   pix_data;

    modport master (
        output filt_valid, filt_data, pix_valid, pix_data,
        input  filt_ready, pix_ready
    );

    modport slave (
        input  filt_valid, filt_data, pix_valid, pix_data,
        output filt_ready, pix_ready
    );

endinterface

`default_nettype wire

// File: rtl/conv_feed_delay.sv
// ============================================================================
// Module   : conv_feed_delay
// Brief    : DEPTH-stage shift register aligning {mac, last} with the array's
//            MAC latency; synchronous flush empties it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_feed_delay
    import conv_feeder_pkg::*;
#(
    parameter int DEPTH = conv_feeder_pkg::MAC_LAT
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     flush,
    input  wire mac_tag_t din,
    output mac_tag_t      dout
);

    mac_tag_t r_pipe [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign dout = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/conv_feeder.sv
// ============================================================================
// Module   : conv_feeder
// Brief    : Per-layer sequencer feeding the convolver array: clear, filter
//            load, pixel stream with window-gated MAC enable, drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_feeder
    import conv_feeder_pkg::*;
#(
    parameter int WID_LINE   = conv_feeder_pkg::WID_LINE,
    parameter int WID_FILTER = conv_feeder_pkg::WID_FILTER,
    parameter int ADDR_FIFO  = conv_feeder_pkg::ADDR_FIFO,
    parameter int K          = conv_feeder_pkg::K,
    parameter int MAC_LAT    = conv_feeder_pkg::MAC_LAT
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    input  wire logic                  abort,
    input  wire logic [ADDR_FIFO-1:0]  cfg_row_length,
    input  wire logic [ADDR_FIFO-1:0]  cfg_n_rows,
    conv_feeder_if.slave               up,
    output logic                       line_buffer_reset,
    output logic [ADDR_FIFO-1:0]       row_length,
    output logic                       shifting_line,
    output logic [WID_LINE-1:0]        input_line,
    output logic                       shifting_filter,
    output logic [WID_FILTER-1:0]      input_filter,
    output logic                       mac_enable,
    output logic                       output_valid,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err
);

    localparam int                   c_filt_w     = $clog2(K*K);
    localparam logic [c_filt_w-1:0]  c_filt_last  = c_filt_w'(K*K-1);
    localparam int                   c_drain_w    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(MAC_LAT-1);
    localparam logic [ADDR_FIFO-1:0] c_k          = ADDR_FIFO'(K);
    localparam logic [ADDR_FIFO-1:0] c_k_m1       = ADDR_FIFO'(K-1);

    state_e                r_state;
    logic [ADDR_FIFO-1:0]  r_n_rows;
    logic [ADDR_FIFO-1:0]  r_col;
    logic [ADDR_FIFO-1:0]  r_row;
    logic [c_filt_w-1:0]   r_filt_cnt;
    logic [c_drain_w-1:0]  r_drain_cnt;
    logic                  r_mac_last;

    logic                  w_filt_hs;
    logic                  w_pix_hs;
    logic                  w_cfg_bad;
    logic                  w_window;
    logic                  w_col_end;
    logic                  w_last_pix;
    logic                  w_flush;
    mac_tag_t              w_tag_in;
    mac_tag_t              w_tag_out;

    assign w_filt_hs  = up.filt_valid & up.filt_ready;
    assign w_pix_hs   = up.pix_valid & up.pix_ready;
    assign w_cfg_bad  = (cfg_row_length < c_k) || (cfg_n_rows < c_k);
    assign w_window   = (r_row >= c_k_m1) && (r_col >= c_k_m1);
    // row_length >= K is guaranteed here, so the subtraction never wraps.
    assign w_col_end  = (r_col == row_length - 1'b1);
    assign w_last_pix = w_col_end && (r_row == r_n_rows - 1'b1);
    assign w_flush    = abort && (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= IDLE;
            r_n_rows          <= '0;
            r_col             <= '0;
            r_row             <= '0;
            r_filt_cnt        <= '0;
            r_drain_cnt       <= '0;
            r_mac_last        <= 1'b0;
            row_length        <= '0;
            line_buffer_reset <= 1'b0;
            shifting_line     <= 1'b0;
            input_line        <= '0;
            shifting_filter   <= 1'b0;
            input_filter      <= '0;
            mac_enable        <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            cfg_err           <= 1'b0;
            up.filt_ready     <= 1'b0;
            up.pix_ready      <= 1'b0;
        end else begin
            line_buffer_reset <= 1'b0;
            shifting_filter   <= 1'b0;
            shifting_line     <= 1'b0;
            mac_enable        <= 1'b0;
            r_mac_last        <= 1'b0;
            done              <= 1'b0;
            cfg_err           <= 1'b0;

            if (w_flush) begin
                r_state       <= IDLE;
                busy          <= 1'b0;
                up.filt_ready <= 1'b0;
                up.pix_ready  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            row_length  <= cfg_row_length;
                            r_n_rows    <= cfg_n_rows;
                            r_col       <= '0;
                            r_row       <= '0;
                            r_filt_cnt  <= '0;
                            r_drain_cnt <= '0;
                            if (w_cfg_bad) begin
                                cfg_err <= 1'b1;
                                done    <= 1'b1;
                            end else begin
                                r_state           <= CLR;
                                busy              <= 1'b1;
                                line_buffer_reset <= 1'b1;
                            end
                        end
                    end
                    CLR: begin
                        r_state       <= LOAD_FILT;
                        up.filt_ready <= 1'b1;
                    end
                    LOAD_FILT: begin
                        if (w_filt_hs) begin
                            shifting_filter <= 1'b1;
                            input_filter    <= up.filt_data;
                            if (r_filt_cnt == c_filt_last) begin
                                up.filt_ready <= 1'b0;
                                up.pix_ready  <= 1'b1;
                                r_state       <= STREAM;
                            end else begin
                                r_filt_cnt <= r_filt_cnt + 1'b1;
                            end
                        end
                    end
                    STREAM: begin
                        if (w_pix_hs) begin
                            shifting_line <= 1'b1;
                            input_line    <= up.pix_data;
                            mac_enable    <= w_window;
                            r_mac_last    <= w_window && w_last_pix;
                            if (w_last_pix) begin
                                up.pix_ready <= 1'b0;
                                r_state      <= DRAIN;
                            end else if (w_col_end) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        // done lands together with the final output_valid.
                        if (r_drain_cnt == c_drain_last) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign w_tag_in = '{mac: mac_enable, last: r_mac_last};

    conv_feed_delay #(
        .DEPTH (MAC_LAT)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .din   (w_tag_in),
        .dout  (w_tag_out)
    );

    assign output_valid = w_tag_out.mac;
    assign out_last     = w_tag_out.last;

endmodule

`default_nettype wire

// File: tb/tb_conv_feeder.sv
// ============================================================================
// Module   : tb_conv_feeder
// Brief    : Directed bench for conv_feeder (row_length=5, n_rows=4, K=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [9:0]  cfg_row_length;
    logic [9:0]  cfg_n_rows;
    logic        line_buffer_reset;
    logic [9:0]  row_length;
    logic        shifting_line;
    logic [15:0] input_line;
    logic        shifting_filter;
    logic [15:0] input_filter;
    logic        mac_enable;
    logic        output_valid;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        cfg_err;

    conv_feeder_if #(.WID_LINE(16), .WID_FILTER(16)) up ();

    conv_feeder dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .cfg_row_length    (cfg_row_length),
        .cfg_n_rows        (cfg_n_rows),
        .up                (up),
        .line_buffer_reset (line_buffer_reset),
        .row_length        (row_length),
        .shifting_line     (shifting_line),
        .input_line        (input_line),
        .shifting_filter   (shifting_filter),
        .input_filter      (input_filter),
        .mac_enable        (mac_enable),
        .output_valid      (output_valid),
        .out_last          (out_last),
        .busy              (busy),
        .done              (done),
        .cfg_err           (cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int cyc = 0;
    int n_lbr, n_sf, n_sl, n_mac, n_ov, n_last, n_done, n_cerr;
    int sf_bad, sl_bad, align_err, first_mac_pix, last_mac_cyc, done_cyc, last_ov_num;
    logic [63:0] mac_mask;
    logic mac_d1, mac_d2;

    // Expected window pixels for the 5x4 frame with K=3: rows 2..3, cols 2..4.
    localparam logic [63:0] EXP_MASK = (64'h7 << 12) | (64'h7 << 17);

    always @(negedge clk) begin
        cyc++;
        if (line_buffer_reset) n_lbr++;
        if (shifting_filter) begin
            if (input_filter !== 16'(16'hC000 + n_sf)) sf_bad++;
            n_sf++;
        end
        if (shifting_line) begin
            if (input_line !== 16'(16'hA000 + n_sl)) sl_bad++;
            if (mac_enable) begin
                if (n_mac == 0) first_mac_pix = n_sl;
                if (n_sl < 64) mac_mask[n_sl] = 1'b1;
            end
            n_sl++;
        end
        if (mac_enable && !shifting_line) align_err++;
        if (mac_enable) begin n_mac++; last_mac_cyc = cyc; end
        if (output_valid !== mac_d2) align_err++;
        if (output_valid) n_ov++;
        if (out_last) begin
            n_last++;
            last_ov_num = n_ov;
            if (!output_valid) align_err++;
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (cfg_err) n_cerr++;
        mac_d2 = mac_d1;
        mac_d1 = mac_enable;
    end

    task automatic clear_mon();
        n_lbr = 0; n_sf = 0; n_sl = 0; n_mac = 0; n_ov = 0; n_last = 0; n_done = 0; n_cerr = 0;
        sf_bad = 0; sl_bad = 0; align_err = 0; first_mac_pix = -1;
        last_mac_cyc = 0; done_cyc = 0; last_ov_num = 0;
        mac_mask = '0; mac_d1 = 1'b0; mac_d2 = 1'b0;
    endtask

    task automatic do_start(input int rl, input int nr);
        cfg_row_length = 10'(rl);
        cfg_n_rows     = 10'(nr);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed_filters(input int n_stop, output bit to);
        int k = 0;
        int g = 0;
        bit hs;
        up.filt_valid = 1'b1;
        up.filt_data  = 16'hC000;
        while (k < n_stop && g < 200) begin
            @(negedge clk);
            hs = up.filt_valid && up.filt_ready;
            @(posedge clk); #1;
            g++;
            if (hs) begin
                k++;
                up.filt_data = 16'(16'hC000 + k);
            end
        end
        up.filt_valid = 1'b0;
        to = (k < n_stop);
    endtask

    task automatic feed_pixels(input int n_pix, input bit gap, input int abort_at,
                               input int start_at, output bit to);
        int k = 0;
        int g = 0;
        bit hs, tog, aborted, started;
        tog = 1'b1; aborted = 1'b0; started = 1'b0;
        up.pix_data = 16'hA000;
        while (k < n_pix && g < 1000 && !aborted) begin
            up.pix_valid = gap ? tog : 1'b1;
            tog = ~tog;
            if (k == abort_at) abort = 1'b1;
            if (k == start_at && !started) begin start = 1'b1; started = 1'b1; end
            @(negedge clk);
            hs = up.pix_valid && up.pix_ready;
            @(posedge clk); #1;
            g++;
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                aborted = 1'b1;
            end else if (hs) begin
                k++;
                up.pix_data = 16'(16'hA000 + k);
            end
        end
        up.pix_valid = 1'b0;
        to = !aborted && (k < n_pix);
    endtask

    task automatic wait_done(output bit to);
        int g = 0;
        while (n_done == 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (4) @(posedge clk);
        #1;
        to = (n_done == 0);
    endtask

    task automatic run_frame(input bit gap, input int abort_at, input int start_at, output bit to);
        bit t1, t2, t3;
        clear_mon();
        do_start(5, 4);
        feed_filters(9, t1);
        feed_pixels(20, gap, abort_at, start_at, t2);
        t3 = 1'b0;
        if (abort_at < 0) wait_done(t3);
        to = t1 | t2 | t3;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_row_length = '0; cfg_n_rows = '0;
        up.filt_valid = 1'b0; up.filt_data = '0; up.pix_valid = 1'b0; up.pix_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset.status: busy=%b done=%b cfg_err=%b want 000", busy, done, cfg_err); end
        n_cmp++; if (up.filt_ready !== 1'b0 || up.pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset.ready: filt=%b pix=%b want 00", up.filt_ready, up.pix_ready); end
        n_cmp++; if (row_length !== 10'd0 || mac_enable !== 1'b0 || output_valid !== 1'b0) begin n_fail++; $display("FAIL reset.data: rl=%0d mac=%b ov=%b want 0", row_length, mac_enable, output_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        bit to;
        run_frame(1'b0, -1, -1, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL full.timeout: got 1 want 0"); end
        n_cmp++; if (n_lbr !== 1) begin n_fail++; $display("FAIL full.lbr: got %0d want 1", n_lbr); end
        n_cmp++; if (n_sf !== 9 || sf_bad !== 0) begin n_fail++; $display("FAIL full.filt: got %0d (bad %0d) want 9 (bad 0)", n_sf, sf_bad); end
        n_cmp++; if (n_sl !== 20 || sl_bad !== 0) begin n_fail++; $display("FAIL full.line: got %0d (bad %0d) want 20 (bad 0)", n_sl, sl_bad); end
        n_cmp++; if (n_mac !== 6 || first_mac_pix !== 12) begin n_fail++; $display("FAIL full.mac: got %0d first %0d want 6 first 12", n_mac, first_mac_pix); end
        n_cmp++; if (mac_mask !== EXP_MASK) begin n_fail++; $display("FAIL full.mask: got %h want %h", mac_mask, EXP_MASK); end
        n_cmp++; if (n_ov !== 6 || align_err !== 0) begin n_fail++; $display("FAIL full.ov: got %0d (align err %0d) want 6 (0)", n_ov, align_err); end
        n_cmp++; if (n_last !== 1 || last_ov_num !== 6) begin n_fail++; $display("FAIL full.last: got %0d at ov %0d want 1 at ov 6", n_last, last_ov_num); end
        n_cmp++; if (n_done !== 1 || done_cyc - last_mac_cyc !== 2) begin n_fail++; $display("FAIL full.done: got %0d gap %0d want 1 gap 2", n_done, done_cyc - last_mac_cyc); end
        n_cmp++; if (busy !== 1'b0 || row_length !== 10'd5 || n_cerr !== 0) begin n_fail++; $display("FAIL full.end: busy=%b rl=%0d cerr=%0d want 0 5 0", busy, row_length, n_cerr); end
    endtask

    task automatic test_gapped();
        bit to;
        run_frame(1'b1, -1, -1, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL gap.timeout: got 1 want 0"); end
        n_cmp++; if (n_sl !== 20 || sl_bad !== 0 || n_sf !== 9) begin n_fail++; $display("FAIL gap.counts: sl=%0d bad=%0d sf=%0d want 20 0 9", n_sl, sl_bad, n_sf); end
        n_cmp++; if (n_mac !== 6 || mac_mask !== EXP_MASK) begin n_fail++; $display("FAIL gap.mac: got %0d mask %h want 6 mask %h", n_mac, mac_mask, EXP_MASK); end
        n_cmp++; if (n_ov !== 6 || align_err !== 0 || last_ov_num !== 6) begin n_fail++; $display("FAIL gap.ov: got %0d err %0d last@%0d want 6 0 6", n_ov, align_err, last_ov_num); end
        n_cmp++; if (n_done !== 1 || done_cyc - last_mac_cyc !== 2) begin n_fail++; $display("FAIL gap.done: got %0d gap %0d want 1 gap 2", n_done, done_cyc - last_mac_cyc); end
    endtask

    task automatic test_cfg_err();
        clear_mon();
        do_start(2, 4);
        n_cmp++; if (cfg_err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL cfgerr.pulse: cfg_err=%b done=%b busy=%b want 1 1 0", cfg_err, done, busy); end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (n_sl !== 0 || n_lbr !== 0 || n_sf !== 0) begin n_fail++; $display("FAIL cfgerr.traffic: sl=%0d lbr=%0d sf=%0d want 0 0 0", n_sl, n_lbr, n_sf); end
        n_cmp++; if (n_cerr !== 1 || n_done !== 1 || up.filt_ready !== 1'b0) begin n_fail++; $display("FAIL cfgerr.once: cerr=%0d done=%0d filt_ready=%b want 1 1 0", n_cerr, n_done, up.filt_ready); end
    endtask

    task automatic test_abort();
        bit to;
        run_frame(1'b0, 11, -1, to);
        n_cmp++; if (busy !== 1'b0 || up.pix_ready !== 1'b0 || shifting_line !== 1'b0) begin n_fail++; $display("FAIL abort.next: busy=%b pix_ready=%b sl=%b want 000", busy, up.pix_ready, shifting_line); end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (n_sl !== 11 || n_ov !== 0 || n_done !== 0) begin n_fail++; $display("FAIL abort.after: sl=%0d ov=%0d done=%0d want 11 0 0", n_sl, n_ov, n_done); end
        run_frame(1'b0, -1, -1, to);
        n_cmp++; if (to || n_sl !== 20 || n_mac !== 6 || n_ov !== 6 || n_done !== 1 || n_lbr !== 1) begin n_fail++; $display("FAIL abort.rerun: to=%b sl=%0d mac=%0d ov=%0d done=%0d lbr=%0d want 0 20 6 6 1 1", to, n_sl, n_mac, n_ov, n_done, n_lbr); end
    endtask

    task automatic test_rst_mid_load();
        bit to;
        clear_mon();
        do_start(5, 4);
        feed_filters(4, to);
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || up.filt_ready !== 1'b0 || shifting_filter !== 1'b0) begin n_fail++; $display("FAIL rst.ctl: busy=%b filt_ready=%b sf=%b want 000", busy, up.filt_ready, shifting_filter); end
        n_cmp++; if (input_filter !== 16'h0 || row_length !== 10'd0 || line_buffer_reset !== 1'b0) begin n_fail++; $display("FAIL rst.data: if=%h rl=%0d lbr=%b want 0 0 0", input_filter, row_length, line_buffer_reset); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(1'b0, -1, -1, to);
        n_cmp++; if (to || n_sf !== 9 || sf_bad !== 0) begin n_fail++; $display("FAIL rst.reload: to=%b sf=%0d bad=%0d want 0 9 0", to, n_sf, sf_bad); end
        n_cmp++; if (n_sl !== 20 || n_ov !== 6 || n_done !== 1) begin n_fail++; $display("FAIL rst.frame: sl=%0d ov=%0d done=%0d want 20 6 1", n_sl, n_ov, n_done); end
    endtask

    task automatic test_start_while_busy();
        bit to;
        run_frame(1'b0, -1, 7, to);
        n_cmp++; if (to || n_lbr !== 1 || n_sf !== 9 || n_sl !== 20) begin n_fail++; $display("FAIL busystart.counts: to=%b lbr=%0d sf=%0d sl=%0d want 0 1 9 20", to, n_lbr, n_sf, n_sl); end
        n_cmp++; if (n_mac !== 6 || n_ov !== 6 || n_done !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL busystart.end: mac=%0d ov=%0d done=%0d busy=%b want 6 6 1 0", n_mac, n_ov, n_done, busy); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_full_frame();
        test_gapped();
        test_cfg_err();
        test_abort();
        test_rst_mid_load();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_feeder.md
Name: conv_feeder

Overview:
- Sequencer that drives the convolver array's input side from two upstream streams: a filter-coefficient stream and a pixel stream.
- Per layer it performs these steps in order:
  - clears the line buffers;
  - loads K*K filter words;
  - streams row_length*n_rows pixels;
  - asserts mac_enable only when a full KxK window is resident;
  - regenerates output_valid, aligned to MAC latency.
- Sits between the activation/weight buffers and the convolver array wrapper.

Parameters:
- WID_LINE, 16, pixel word width (matches `WID_LINE).
- WID_FILTER, 16, filter word width (matches `WID_FILTER).
- ADDR_FIFO, 10, row length / row count width (matches `ADDR_FIFO).
- K, 3, filter edge size; K*K coefficients per load.
- MAC_LAT, 2, cycles from mac_enable to convolver result valid; must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- start  in  1  single-cycle pulse that starts a layer. Accepted only in IDLE.
- abort  in  1  synchronous abort. Returns the block to IDLE.
- cfg_row_length  in  ADDR_FIFO  pixels per row. Latched on start.
- cfg_n_rows  in  ADDR_FIFO  rows per frame. Latched on start.
- filt_valid / filt_ready / filt_data  in/out/in  1/1/WID_FILTER  filter stream.
- pix_valid / pix_ready / pix_data  in/out/in  1/1/WID_LINE  pixel stream.
- line_buffer_reset  out  1  line buffer clear.
- row_length  out  ADDR_FIFO  latched row length, held for the whole layer.
- shifting_line  out  1  pixel shift strobe.
- input_line  out  WID_LINE  pixel to the array.
- shifting_filter  out  1  filter shift strobe.
- input_filter  out  WID_FILTER  coefficient to the array.
- mac_enable  out  1  window valid; MAC fires this cycle.
- output_valid  out  1  array result valid.
- out_last  out  1  qualifies the final output_valid of the frame.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle pulse at end of layer.
- cfg_err  out  1  one-cycle pulse when the configuration is illegal.

Behaviour:
- Reset value of every output is 0. Reset also zeroes row_length and all counters.
- All outputs are registered.

State machine: IDLE → CLR → LOAD_FILT → STREAM → DRAIN → IDLE.
- IDLE:
  - On start, latch the cfg values.
  - If cfg_row_length < K or cfg_n_rows < K: pulse cfg_err and done the next cycle, generate no traffic, stay in IDLE.
  - Otherwise go to CLR.
- CLR: line_buffer_reset=1 for exactly 1 cycle, then go to LOAD_FILT.
- LOAD_FILT:
  - filt_ready=1.
  - Each handshake produces, on the next cycle, shifting_filter=1 and input_filter=filt_data.
  - After K*K handshakes, go to STREAM.
  - filt_ready drops the cycle after the K*K-th handshake.
- STREAM:
  - pix_ready=1.
  - Each handshake produces, on the next cycle, shifting_line=1 and input_line=pix_data.
  - Column counter col counts 0..row_length-1 and wraps, incrementing row.
  - mac_enable is asserted in the same cycle as shifting_line iff the shifted pixel's row ≥ K-1 and col ≥ K-1.
  - On the handshake of pixel (n_rows-1, row_length-1), drop pix_ready and go to DRAIN.
- DRAIN:
  - Wait until the output_valid pipeline is empty, i.e. MAC_LAT cycles after the last mac_enable.
  - Then pulse done for 1 cycle and go to IDLE.
- Gaps in pix_valid or filt_valid produce gap cycles with the strobes low. Counters hold during gaps.
- output_valid equals mac_enable delayed by exactly MAC_LAT cycles.
- out_last equals the final mac_enable of the frame delayed by MAC_LAT cycles.
- Window count per frame = (row_length-K+1)*(n_rows-K+1).
- abort (any state except IDLE):
  - Next cycle: state=IDLE, all strobes and ready signals 0, delay pipeline flushed, no done pulse.
  - abort has priority over start and over handshakes in the same cycle.
- start while busy is ignored.
- rst mid-frame: immediate return to reset values; an upstream handshake in flight is discarded.
- Counter widths are ADDR_FIFO bits. The row_length = 2^ADDR_FIFO-1 maximum must not overflow the col compare.

Decomposition:
- Shared header (header.vh / conv_pkg) holds:
  - WID_LINE, WID_FILTER, ADDR_FIFO, K;
  - MAC_LAT;
  - state encodings: IDLE=0, CLR=1, LOAD_FILT=2, STREAM=3, DRAIN=4.
- One sub-module: conv_feed_delay, a MAC_LAT-deep shift register carrying {mac_enable, last}, with async reset and synchronous flush.

Test Plan:
- row_length=5, n_rows=4, K=3, MAC_LAT=2, continuous valid:
  - exactly 1 line_buffer_reset, 9 shifting_filter, 20 shifting_line;
  - 6 mac_enable pulses, the first on pixel index 12;
  - output_valid 2 cycles after each mac_enable;
  - out_last on the 6th output_valid;
  - done 2 cycles after the last mac_enable.
- Same configuration, pix_valid toggling every other cycle: identical counts and ordering; the number of mac_enable cycles between gaps is unchanged.
- cfg_row_length=2 with start: cfg_err=1 and done=1 next cycle; zero shifting_line and zero line_buffer_reset.
- abort asserted after pixel 10: next cycle busy=0, pix_ready=0, no further output_valid, no done. A following start runs a clean full frame.
- rst asserted mid-LOAD_FILT after 4 coefficients: all outputs 0 immediately. A new start reloads all 9 coefficients.
- start pulsed during STREAM: ignored; counts stay the same as in the first scenario.
